// File: rtl/axi_err_slv.sv
// AXI4 error slave: terminates every AR/AW with a fixed error response.
// Reads return len+1 constant beats. Writes are drained fully, then get one B.
// Request queues on both paths keep the crossbar from deadlocking.
module axi_err_slv #(
  parameter int unsigned                    AxiIdWidth   = 4,
  parameter int unsigned                    AxiAddrWidth = 32,
  parameter int unsigned                    AxiDataWidth = 64,
  parameter logic [1:0]                     RespCode     = 2'b11,
  parameter logic [AxiDataWidth-1:0]        ReadDataWord = '0,
  parameter int unsigned                    MaxReads     = 2,
  parameter int unsigned                    MaxWrites    = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  // read address
  input  logic [AxiIdWidth-1:0]     ar_id,
  input  logic [AxiAddrWidth-1:0]   ar_addr,
  input  logic [7:0]                ar_len,
  input  logic                      ar_valid,
  output logic                      ar_ready,
  // read data
  output logic [AxiIdWidth-1:0]     r_id,
  output logic [AxiDataWidth-1:0]   r_data,
  output logic [1:0]                r_resp,
  output logic                      r_last,
  output logic                      r_valid,
  input  logic                      r_ready,
  // write address
  input  logic [AxiIdWidth-1:0]     aw_id,
  input  logic [AxiAddrWidth-1:0]   aw_addr,
  input  logic [7:0]                aw_len,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  // write data
  input  logic [AxiDataWidth-1:0]   w_data,
  input  logic [AxiDataWidth/8-1:0] w_strb,
  input  logic                      w_last,
  input  logic                      w_valid,
  output logic                      w_ready,
  // write response
  output logic [AxiIdWidth-1:0]     b_id,
  output logic [1:0]                b_resp,
  output logic                      b_valid,
  input  logic                      b_ready
);

  localparam int unsigned RqPtrW = (MaxReads > 1) ? $clog2(MaxReads) : 1;
  localparam int unsigned RqCntW = $clog2(MaxReads + 1);
  localparam int unsigned WqPtrW = (MaxWrites > 1) ? $clog2(MaxWrites) : 1;
  localparam int unsigned WqCntW = $clog2(MaxWrites + 1);

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  // Address, length-of-write and write payload carry no meaning for an error target.
  logic unused_c;
  assign unused_c = ^{ar_addr, aw_addr, aw_len, w_data, w_strb};

  // ---------------------------------------------------------------------------
  // Read request queue: FIFO of {id, len}
  // ---------------------------------------------------------------------------
  logic [AxiIdWidth-1:0] rq_id_q  [MaxReads];
  logic [7:0]            rq_len_q [MaxReads];
  logic [RqPtrW-1:0]     rq_wr_q, rq_rd_q;
  logic [RqCntW-1:0]     rq_cnt_q;
  logic                  rq_full_c, rq_empty_c, rq_push_c, rq_pop_c;

  assign rq_full_c  = (rq_cnt_q == RqCntW'(MaxReads));
  assign rq_empty_c = (rq_cnt_q == '0);
  assign rq_push_c  = ar_valid && !rq_full_c;

  // Read queue storage; contents need no reset because the count gates them.
  always_ff @(posedge clk) begin
    if (rq_push_c) begin
      rq_id_q[rq_wr_q]  <= ar_id;
      rq_len_q[rq_wr_q] <= ar_len;
    end
  end

  // Read queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rq_wr_q  <= '0;
      rq_rd_q  <= '0;
      rq_cnt_q <= '0;
    end else begin
      if (rq_push_c) rq_wr_q <= (rq_wr_q == RqPtrW'(MaxReads - 1)) ? '0 : rq_wr_q + RqPtrW'(1);
      if (rq_pop_c)  rq_rd_q <= (rq_rd_q == RqPtrW'(MaxReads - 1)) ? '0 : rq_rd_q + RqPtrW'(1);
      case ({rq_push_c, rq_pop_c})
        2'b10:   rq_cnt_q <= rq_cnt_q + RqCntW'(1);
        2'b01:   rq_cnt_q <= rq_cnt_q - RqCntW'(1);
        default: rq_cnt_q <= rq_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read burst FSM
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [7:0]            beat_q, beat_d;
  logic [AxiIdWidth-1:0] rid_q, rid_d;

  // Read FSM state, beat counter and latched ID.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_state_q <= RD_IDLE;
      beat_q     <= '0;
      rid_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      beat_q     <= beat_d;
      rid_q      <= rid_d;
    end
  end

  // Next state: IDLE pops the head request, BURST counts beats down to zero.
  always_comb begin
    rd_state_d = rd_state_q;
    beat_d     = beat_q;
    rid_d      = rid_q;
    rq_pop_c   = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (!rq_empty_c) begin
          rq_pop_c   = 1'b1;
          beat_d     = rq_len_q[rq_rd_q];
          rid_d      = rq_id_q[rq_rd_q];
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (r_ready) begin
          if (beat_q == 8'd0) rd_state_d = RD_IDLE;
          else                beat_d     = beat_q - 8'd1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign ar_ready = !rq_full_c;
  assign r_valid  = (rd_state_q == RD_BURST);
  assign r_last   = (rd_state_q == RD_BURST) && (beat_q == 8'd0);
  assign r_id     = rid_q;
  assign r_data   = ReadDataWord;
  assign r_resp   = RespCode;

  // ---------------------------------------------------------------------------
  // Write path: AW id queue and completed-W-burst counter, fully decoupled
  // ---------------------------------------------------------------------------
  logic [AxiIdWidth-1:0] wq_id_q [MaxWrites];
  logic [WqPtrW-1:0]     wq_wr_q, wq_rd_q;
  logic [WqCntW-1:0]     wq_cnt_q;
  logic [WqCntW-1:0]     wdone_q, wdone_d;
  logic                  wq_full_c, wq_empty_c, wq_push_c, b_hs_c, wlast_hs_c;

  assign wq_full_c  = (wq_cnt_q == WqCntW'(MaxWrites));
  assign wq_empty_c = (wq_cnt_q == '0);
  assign wq_push_c  = aw_valid && !wq_full_c;
  assign b_hs_c     = b_valid && b_ready;
  assign wlast_hs_c = w_valid && w_ready && w_last;

  // AW id storage; contents gated by the count, so no reset.
  always_ff @(posedge clk) begin
    if (wq_push_c) wq_id_q[wq_wr_q] <= aw_id;
  end

  // AW queue pointers and occupancy; a B handshake retires the head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wq_wr_q  <= '0;
      wq_rd_q  <= '0;
      wq_cnt_q <= '0;
    end else begin
      if (wq_push_c) wq_wr_q <= (wq_wr_q == WqPtrW'(MaxWrites - 1)) ? '0 : wq_wr_q + WqPtrW'(1);
      if (b_hs_c)    wq_rd_q <= (wq_rd_q == WqPtrW'(MaxWrites - 1)) ? '0 : wq_rd_q + WqPtrW'(1);
      case ({wq_push_c, b_hs_c})
        2'b10:   wq_cnt_q <= wq_cnt_q + WqCntW'(1);
        2'b01:   wq_cnt_q <= wq_cnt_q - WqCntW'(1);
        default: wq_cnt_q <= wq_cnt_q;
      endcase
    end
  end

  // Completed-burst count: +1 on a last beat, -1 on a B handshake, both cancel.
  always_comb begin
    wdone_d = wdone_q;
    case ({wlast_hs_c, b_hs_c})
      2'b10:   wdone_d = wdone_q + WqCntW'(1);
      2'b01:   wdone_d = wdone_q - WqCntW'(1);
      default: wdone_d = wdone_q;
    endcase
  end

  // Completed-burst count register.
  always_ff @(posedge clk) begin
    if (!rstn) wdone_q <= '0;
    else       wdone_q <= wdone_d;
  end

  assign aw_ready = !wq_full_c;
  assign w_ready  = (wdone_q < WqCntW'(MaxWrites));
  assign b_valid  = !wq_empty_c && (wdone_q != '0);
  assign b_id     = wq_id_q[wq_rd_q];
  assign b_resp   = RespCode;

endmodule
